// File: rtl/domd_state_serpar_if.sv
// domd_state_serpar_if: bundle of the operation, public-data and round-core
// signals exchanged between the mode controller (master) and the masked
// state register (slave).
//   start/op/busy/done           operation request and status
//   pdi_data/pdi_valid/pdi_ready public input word handshake
//   rnd                          (D-1) fresh mask words per input transfer
//   pdo_data/pdo_valid/pdo_ready public output word handshake
//   core_en/rnd_idx              round core enable and round index
//   core_out/core_in             D shares to / from the round core
interface domd_state_serpar_if #(
  parameter int D = 2,
  parameter int W = 32
);
  logic                 start;
  logic [2:0]           op;
  logic                 busy;
  logic                 done;
  logic [W-1:0]         pdi_data;
  logic                 pdi_valid;
  logic                 pdi_ready;
  logic [(D-1)*W-1:0]   rnd;
  logic [W-1:0]         pdo_data;
  logic                 pdo_valid;
  logic                 pdo_ready;
  logic                 core_en;
  logic [5:0]           rnd_idx;
  logic [128*D-1:0]     core_out;
  logic [128*D-1:0]     core_in;

  modport master (
    output start, op, pdi_data, pdi_valid, rnd, pdo_ready, core_in,
    input  busy, done, pdi_ready, pdo_data, pdo_valid, core_en, rnd_idx, core_out
  );

  modport slave (
    input  start, op, pdi_data, pdi_valid, rnd, pdo_ready, core_in,
    output busy, done, pdi_ready, pdo_data, pdo_valid, core_en, rnd_idx, core_out
  );
endinterface

// File: rtl/domd_state_serpar.sv
// domd_state_serpar: 128-bit Romulus-N TBC state held as D Boolean shares.
// Exchanges the state with the public bus one W-bit word per transfer
// (rho absorb/encrypt/decrypt, tag squeeze) and sequences the masked round
// core for NR cycles.
//   clk  : clock
//   rst  : synchronous active-high reset (aborts any operation, zeroes shares)
//   bus  : domd_state_serpar_if slave modport (handshakes, rnd, core ports)
module domd_state_serpar #(
  parameter int D  = 2,
  parameter int W  = 32,
  parameter int NR = 40
) (
  input  logic                    clk,
  input  logic                    rst,
  domd_state_serpar_if.slave      bus
);

  localparam int NW = 128 / W;
  localparam int CW = (NW > 1) ? $clog2(NW) : 1;

  localparam logic [2:0] OP_ABS    = 3'd0;
  localparam logic [2:0] OP_ENC    = 3'd1;
  localparam logic [2:0] OP_DEC    = 3'd2;
  localparam logic [2:0] OP_SQZ    = 3'd3;
  localparam logic [2:0] OP_ROUNDS = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_RUN  = 2'd2
  } state_e;

  state_e                 state_q;
  logic [2:0]             op_q;
  logic [CW-1:0]          cnt_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   core_en_q;
  logic [5:0]             rnd_idx_q;
  logic [D-1:0][127:0]    sh_q;
  logic [D-1:0][127:0]    sh_d;

  logic                   is_xfer_s;
  logic                   in_ok_s;
  logic                   out_ok_s;
  logic                   fire_s;
  logic [W-1:0]           u_s;
  logic [W-1:0]           gu_s;
  logic [W-1:0]           p_s;
  logic [W-1:0]           r_all_s;
  logic [D-1:0][W-1:0]    r_w_s;
  logic [W-1:0]           pdo_word_s;

  // Romulus G on every byte: out = (b >> 1) | ((b[0] ^ b[7]) << 7)
  function automatic logic [W-1:0] g_fn(input logic [W-1:0] x);
    logic [W-1:0] y;
    y = '0;
    for (int b = 0; b < W / 8; b++) begin
      y[8*b +: 7] = x[8*b+1 +: 7];
      y[8*b+7]    = x[8*b] ^ x[8*b+7];
    end
    return y;
  endfunction

  assign is_xfer_s = (state_q == S_XFER);
  assign in_ok_s   = (op_q == OP_SQZ) | bus.pdi_valid;
  assign out_ok_s  = (op_q == OP_ABS) | bus.pdo_ready;
  assign fire_s    = is_xfer_s & in_ok_s & out_ok_s;

  // Transfer datapath: unmasked top word, rho plaintext, and next shares
  always_comb begin
    logic [W-1:0] top_v;
    u_s     = '0;
    r_all_s = '0;
    r_w_s   = '0;
    for (int i = 0; i < D; i++) begin
      u_s = u_s ^ sh_q[i][127 -: W];
    end
    for (int i = 1; i < D; i++) begin
      r_w_s[i] = bus.rnd[(i-1)*W +: W];
      r_all_s  = r_all_s ^ r_w_s[i];
    end
    gu_s = g_fn(u_s);
    if (op_q == OP_DEC) begin
      p_s = bus.pdi_data ^ gu_s;
    end else begin
      p_s = bus.pdi_data;
    end
    if (op_q == OP_SQZ) begin
      pdo_word_s = gu_s;
    end else begin
      pdo_word_s = bus.pdi_data ^ gu_s;
    end
    // Share 0 absorbs P masked by all fresh words, so P is re-shared fresh
    for (int i = 0; i < D; i++) begin
      top_v = sh_q[i][127 -: W];
      if (op_q != OP_SQZ) begin
        if (i == 0) begin
          top_v = top_v ^ p_s ^ r_all_s;
        end else begin
          top_v = top_v ^ r_w_s[i];
        end
      end else begin
        top_v = top_v;
      end
      sh_d[i] = {sh_q[i][127-W:0], top_v};
    end
  end

  assign bus.pdi_ready = is_xfer_s & (op_q != OP_SQZ) & out_ok_s;
  assign bus.pdo_valid = is_xfer_s & (op_q != OP_ABS) & in_ok_s;
  assign bus.pdo_data  = bus.pdo_valid ? pdo_word_s : '0;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.core_en   = core_en_q;
  assign bus.rnd_idx   = rnd_idx_q;
  assign bus.core_out  = sh_q;

  // Control FSM with registered status outputs and share storage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= 3'd0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      core_en_q <= 1'b0;
      rnd_idx_q <= 6'd0;
      sh_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            case (bus.op)
              OP_ABS, OP_ENC, OP_DEC, OP_SQZ: begin
                state_q <= S_XFER;
                op_q    <= bus.op;
                busy_q  <= 1'b1;
              end
              OP_ROUNDS: begin
                state_q   <= S_RUN;
                op_q      <= bus.op;
                busy_q    <= 1'b1;
                core_en_q <= 1'b1;
                rnd_idx_q <= 6'd0;
              end
              default: begin
                // CLEAR and reserved codes: wipe shares, finish immediately
                sh_q   <= '0;
                done_q <= 1'b1;
              end
            endcase
          end
        end
        S_XFER: begin
          if (fire_s) begin
            sh_q <= sh_d;
            if (cnt_q == CW'(NW - 1)) begin
              cnt_q   <= '0;
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        S_RUN: begin
          sh_q <= bus.core_in;
          if (rnd_idx_q == 6'(NR - 1)) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            core_en_q <= 1'b0;
            rnd_idx_q <= 6'd0;
            done_q    <= 1'b1;
          end else begin
            rnd_idx_q <= rnd_idx_q + 6'd1;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          busy_q    <= 1'b0;
          core_en_q <= 1'b0;
          rnd_idx_q <= 6'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_domd_state_serpar.sv
module tb_domd_state_serpar;
  localparam int D  = 2;
  localparam int W  = 32;
  localparam int NR = 40;
  localparam logic [2:0] ABS = 3'd0, ENC = 3'd1, DEC = 3'd2, SQZ = 3'd3;
  localparam logic [2:0] CLR = 3'd4, RND = 3'd5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  domd_state_serpar_if #(.D(D), .W(W)) bus();
  domd_state_serpar #(.D(D), .W(W), .NR(NR)) dut (.clk(clk), .rst(rst), .bus(bus));

  int cmode = 0;
  function automatic logic [127:0] rotl1(input logic [127:0] x);
    return {x[126:0], x[127]};
  endfunction
  for (genvar i = 0; i < D; i++) begin : g_core
    assign bus.core_in[128*i +: 128] = (cmode == 0) ? ~bus.core_out[128*i +: 128]
                                                    : rotl1(bus.core_out[128*i +: 128]);
  end

  // Reference: unmasked state as four plain words, index 0 = most significant
  logic [31:0] st [4];
  logic [31:0] din [4];
  logic [31:0] rlog [4];
  logic [31:0] out_log [$];
  int errs = 0, checks = 0, done_cnt = 0, exp_done = 0;

  logic        e_on = 1'b0, e_busy, e_done, e_pdi_ready, e_pdo_valid, e_core_en;
  logic [31:0] e_pdo_data;
  logic [5:0]  e_rnd_idx;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] g32(input logic [31:0] x);
    logic [31:0] y;
    logic [7:0] v;
    for (int b = 0; b < 4; b++) begin
      v = x[8*b +: 8];
      y[8*b +: 8] = 8'((v >> 1) | (8'(v[0] ^ v[7]) << 7));
    end
    return y;
  endfunction

  function automatic logic [127:0] model_v();
    return {st[0], st[1], st[2], st[3]};
  endfunction

  function automatic logic [127:0] unmask();
    logic [127:0] a;
    a = '0;
    for (int i = 0; i < D; i++) a = a ^ bus.core_out[128*i +: 128];
    return a;
  endfunction

  function automatic logic [31:0] logw(input int i);
    if (i < out_log.size()) return out_log[i];
    return 32'hxxxxxxxx;
  endfunction

  // Per-cycle compare of DUT outputs against the expectations set by the stimulus
  always @(negedge clk) begin
    if (!rst) begin
      if (!bus.pdo_valid) chk("pdo_zero_when_invalid", 128'(bus.pdo_data), 128'(0));
      if (bus.pdo_valid && bus.pdo_ready) out_log.push_back(bus.pdo_data);
      if (bus.done) done_cnt++;
      if (e_on) begin
        chk("busy", 128'(bus.busy), 128'(e_busy));
        chk("done", 128'(bus.done), 128'(e_done));
        chk("pdi_ready", 128'(bus.pdi_ready), 128'(e_pdi_ready));
        chk("pdo_valid", 128'(bus.pdo_valid), 128'(e_pdo_valid));
        chk("pdo_data", 128'(bus.pdo_data), 128'(e_pdo_data));
        chk("core_en", 128'(bus.core_en), 128'(e_core_en));
        chk("rnd_idx", 128'(bus.rnd_idx), 128'(e_rnd_idx));
        if (!e_busy) chk("unmasked_state", unmask(), model_v());
      end
    end
  end

  task automatic set_idle_exp(input logic dn);
    e_on = 1'b1; e_busy = 1'b0; e_done = dn; e_pdi_ready = 1'b0; e_pdo_valid = 1'b0;
    e_pdo_data = 32'd0; e_core_en = 1'b0; e_rnd_idx = 6'd0;
  endtask

  // Word transfer operation; nstop < 4 stops early (used for the reset abort)
  task automatic do_xfer(input logic [2:0] opc, input int rmode, input int vmode, input int nstop);
    int k, cyc;
    logic [31:0] g, w;
    logic inok, outok;
    k = 0; cyc = 0;
    out_log.delete();
    e_on = 1'b0;
    bus.op = opc; bus.start = 1'b1;
    @(posedge clk); #1;
    while (k < nstop && cyc < 200) begin
      bus.start = 1'(cyc == 1);
      if (cyc == 1) bus.op = 3'($urandom_range(0, 7));
      bus.pdi_data  = din[k];
      bus.pdi_valid = (vmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.rnd       = $urandom();
      case (rmode)
        0:       bus.pdo_ready = 1'b1;
        1:       bus.pdo_ready = 1'((cyc % 4 == 0) || (cyc % 4 == 3));
        default: bus.pdo_ready = 1'($urandom_range(0, 1));
      endcase
      inok  = (opc == SQZ) || bus.pdi_valid;
      outok = (opc == ABS) || bus.pdo_ready;
      g = g32(st[k]);
      w = (opc == SQZ) ? g : (din[k] ^ g);
      e_on = 1'b1; e_busy = 1'b1; e_done = 1'b0; e_core_en = 1'b0; e_rnd_idx = 6'd0;
      e_pdi_ready = (opc != SQZ) && outok;
      e_pdo_valid = (opc != ABS) && inok;
      e_pdo_data  = e_pdo_valid ? w : 32'd0;
      if (inok && outok) begin
        case (opc)
          ABS, ENC: st[k] = st[k] ^ din[k];
          DEC:      st[k] = st[k] ^ w;
          default:  ;
        endcase
        rlog[k] = bus.rnd;
        k++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.start = 1'b0;
    bus.pdi_valid = 1'($urandom_range(0, 1));
    bus.pdo_ready = 1'($urandom_range(0, 1));
    if (k < nstop) chk("xfer_cycle_budget", 128'(k), 128'(nstop));
    if (nstop == 4) begin
      set_idle_exp(1'b1); exp_done++;
      @(negedge clk); #1;
    end
    e_on = 1'b0;
  endtask

  task automatic do_clear();
    out_log.delete();
    e_on = 1'b0;
    bus.op = CLR; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 0; k < 4; k++) st[k] = 32'd0;
    set_idle_exp(1'b1); exp_done++;
    @(negedge clk); #1;
    e_on = 1'b0;
  endtask

  // cm=0: core inverts every share; cm=1: core rotates every share left by 1
  task automatic do_rounds(input int cm);
    logic [127:0] m;
    cmode = cm;
    e_on = 1'b0;
    bus.op = RND; bus.start = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < NR; i++) begin
      bus.start = 1'(i == 4);
      bus.op = (i == 4) ? CLR : RND;
      e_on = 1'b1; e_busy = 1'b1; e_done = 1'b0; e_pdi_ready = 1'b0; e_pdo_valid = 1'b0;
      e_pdo_data = 32'd0; e_core_en = 1'b1; e_rnd_idx = 6'(i);
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    m = model_v();
    if (cm == 0) begin
      if (NR % 2 == 1) m = ~m;
    end else begin
      m = {m[127-NR:0], m[127:128-NR]};
    end
    {st[0], st[1], st[2], st[3]} = m;
    set_idle_exp(1'b1); exp_done++;
    @(negedge clk); #1;
    e_on = 1'b0;
  endtask

  task automatic idle_gap(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.pdi_valid = 1'($urandom_range(0, 1));
      set_idle_exp(1'b0);
      @(negedge clk); #1;
      e_on = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.op = 3'd0; bus.pdi_data = 32'd0; bus.pdi_valid = 1'b1;
    bus.rnd = '0; bus.pdo_ready = 1'b0;
    for (int k = 0; k < 4; k++) st[k] = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 128'(bus.busy), 128'(0));
    chk("rst_done", 128'(bus.done), 128'(0));
    chk("rst_core_en", 128'(bus.core_en), 128'(0));
    chk("rst_rnd_idx", 128'(bus.rnd_idx), 128'(0));
    chk("rst_pdi_ready", 128'(bus.pdi_ready), 128'(0));
    chk("rst_pdo_valid", 128'(bus.pdo_valid), 128'(0));
    chk("rst_shares", bus.core_out[127:0] | bus.core_out[255:128], 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    idle_gap(2);

    // Absorb 0x01010101 x4 from a zero state, then squeeze
    for (int k = 0; k < 4; k++) din[k] = 32'h01010101;
    do_xfer(ABS, 0, 0, 4);
    chk("abs_unmasked_lit", unmask(), {4{32'h01010101}});
    chk("abs_share1_is_rnd", bus.core_out[255:128], {rlog[0], rlog[1], rlog[2], rlog[3]});
    for (int k = 0; k < 4; k++) din[k] = $urandom();
    do_xfer(SQZ, 0, 1, 4);
    for (int k = 0; k < 4; k++) chk("sqz_word_lit", 128'(logw(k)), 128'(32'h80808080));
    chk("sqz_state_kept_lit", unmask(), {4{32'h01010101}});

    // Clear, encrypt from zero state (C == P), then chained decrypt of zeros
    do_clear();
    din[0] = 32'hDEADBEEF; din[1] = 32'd0; din[2] = 32'd0; din[3] = 32'd0;
    do_xfer(ENC, 0, 0, 4);
    chk("enc_c0_lit", 128'(logw(0)), 128'(32'hDEADBEEF));
    for (int k = 1; k < 4; k++) chk("enc_ck_lit", 128'(logw(k)), 128'(0));
    for (int k = 0; k < 4; k++) din[k] = 32'd0;
    do_xfer(DEC, 0, 0, 4);
    // G bytes: DE->EF, AD->56, BE->DF, EF->77
    chk("dec_p0_lit", 128'(logw(0)), 128'(32'hEF56DF77));
    for (int k = 1; k < 4; k++) chk("dec_pk_lit", 128'(logw(k)), 128'(0));

    // Encrypt with pdo_ready pattern 1-0-0-1
    for (int k = 0; k < 4; k++) din[k] = $urandom();
    do_xfer(ENC, 1, 0, 4);
    chk("enc_stall_count", 128'(out_log.size()), 128'(4));

    // Rounds: inverting core (even count restores state), then rotating core
    idle_gap(1);
    do_rounds(0);
    do_rounds(1);

    // Reset in the middle of an absorb, then a fresh absorb
    for (int k = 0; k < 4; k++) din[k] = $urandom();
    do_xfer(ABS, 0, 0, 2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) st[k] = 32'd0;
    set_idle_exp(1'b0);
    @(negedge clk); #1;
    e_on = 1'b0;
    chk("rst_abort_shares", bus.core_out[127:0] | bus.core_out[255:128], 128'(0));
    do_xfer(ABS, 0, 0, 4);
    chk("abs_after_rst_share1", bus.core_out[255:128], {rlog[0], rlog[1], rlog[2], rlog[3]});

    // Randomized operation mix
    for (int t = 0; t < 40; t++) begin
      int r;
      r = $urandom_range(0, 5);
      for (int k = 0; k < 4; k++) din[k] = $urandom();
      case (r)
        0, 1, 2, 3: do_xfer(3'(r), $urandom_range(0, 2), $urandom_range(0, 1), 4);
        4:          do_clear();
        default:    do_rounds($urandom_range(0, 1));
      endcase
      if ($urandom_range(0, 1) == 1) idle_gap($urandom_range(1, 3));
    end
    idle_gap(2);

    chk("done_pulse_count", 128'(done_cnt), 128'(exp_done));
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
